// File: rtl/spi_stream_arbiter_pkg.sv
// Shared arbiter types and the round-robin "next set bit from pointer" search.
package spi_stream_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    // Widest request vector the search function handles; callers zero-extend.
    localparam int RR_MAX_REQ = 8;

    typedef struct packed {
        logic       any;
        logic [2:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping modulo n (n <= RR_MAX_REQ).
    // ptr < n and k < n keep ptr + k below 2n, so one subtraction wraps it.
    function automatic rr_pick_t rr_next_set(input logic [RR_MAX_REQ-1:0] req,
                                             input logic [2:0]            ptr,
                                             input int                    n);
        rr_pick_t r;
        int       idx;
        r = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !r.any && req[idx[2:0]]) begin
                r.any = 1'b1;
                r.idx = idx[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_stream_arbiter_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr.
module rr_priority_pick
    import spi_stream_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               any
);

    rr_pick_t pick;

    // Widen to the shared function's fixed width, then narrow the result back.
    always_comb begin
        pick = rr_next_set(RR_MAX_REQ'(req), 3'(ptr), NUM_REQ);
        idx  = IW'(pick.idx);
        any  = pick.any;
    end

endmodule

// File: rtl/spi_stream_arbiter.sv
// Packet-atomic round-robin arbiter feeding the SPI slave's host-bound byte
// stream. A grant is held until the grantee's last beat or the beat limit.
module spi_stream_arbiter
    import spi_stream_arbiter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         busy,
    output logic [NUM_REQ-1:0]           overflow
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BEATS);

    arb_state_e    state, state_nxt;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic [CW-1:0] beat_cnt;
    logic          accept;
    logic          last_g;
    logic          at_max;
    logic          grant_end;
    logic [IW-1:0] grant_inc;

    rr_priority_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req (req_vld),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Beat accounting for the current grantee; the limit cuts the grant on
    // the beat that brings the count to MAX_BEATS, so beat_cnt never wraps.
    always_comb begin
        accept    = (state == ARB_GRANT) && req_vld[grant_id] && out_rdy;
        last_g    = req_last[grant_id];
        at_max    = (beat_cnt == CW'(MAX_BEATS - 1));
        grant_end = accept && (last_g || at_max);
        grant_inc = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    // Next state and the combinational pass-through of the grantee.
    always_comb begin
        state_nxt = state;
        out_vld   = 1'b0;
        out_data  = '0;
        req_rdy   = '0;
        busy      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) state_nxt = ARB_GRANT;
            end
            ARB_GRANT: begin
                busy              = 1'b1;
                out_data          = req_data[grant_id*WIDTH +: WIDTH];
                out_vld           = req_vld[grant_id];
                req_rdy[grant_id] = out_rdy;
                if (grant_end) state_nxt = ARB_IDLE;
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    // Grant bookkeeping: latch the winner, count beats, advance the pointer
    // past the grantee at grant end, and flag limit cut-offs (sticky).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            overflow <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_any) begin
                grant_id <= pick_idx;
                beat_cnt <= '0;
            end
        end else if (accept) begin
            if (grant_end) begin
                rr_ptr <= grant_inc;
                if (at_max && !last_g) overflow[grant_id] <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

endmodule
